// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and users of the shifter:
// operation codes, shifter control codes and sequencer state encodings.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        OP_LSR = 2'b00,
        OP_LSL = 2'b01,
        OP_ASR = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        SH_NOP   = 3'b000,
        SH_LSR1  = 3'b001,
        SH_LSL1  = 3'b010,
        SH_LSL16 = 3'b011,
        SH_ASR1  = 3'b101
    } sh_ctrl_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 5;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Single-step combinational shifter used on the sequencer work register.
// Ports: ctrl (step code), a (operand), y (result),
//        cout (bit(s) shifted out), overflow (sign bit changed).
module shifter
    import shift_sequencer_pkg::*;
(
    input  sh_ctrl_e          ctrl,
    input  logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] y,
    output logic              cout,
    output logic              overflow
);

    always_comb begin
        y        = a;
        cout     = 1'b0;
        overflow = 1'b0;
        case (ctrl)
            SH_LSR1: begin
                y        = {1'b0, a[31:1]};
                cout     = a[0];
                overflow = a[31];
            end
            SH_LSL1: begin
                y        = {a[30:0], 1'b0};
                cout     = a[31];
                overflow = a[31] ^ a[30];
            end
            SH_LSL16: begin
                // Flags match sixteen 1-bit steps: any lost bit sets
                // cout, any sign flip along the way sets overflow.
                y        = {a[15:0], 16'h0000};
                cout     = |a[31:16];
                overflow = ~((&a[31:15]) | ~(|a[31:15]));
            end
            SH_ASR1: begin
                y    = {a[31], a[31:1]};
                cout = a[0];
            end
            default: begin
                y = a;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift sequencer: accepts one LSR/LSL/ASR request in IDLE
// and walks the work register through the shifter one step per cycle.
// Ports: clk, rst (async, active-high), start, op, amount, din in;
//        busy, done (1-cycle pulse), dout, cout, overflow (sticky) out.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [CNT_W-1:0]  amount,
    input  logic [DATA_W-1:0] din,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dout,
    output logic              cout,
    output logic              overflow
);

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    sh_ctrl_e          step_ctrl;
    logic [CNT_W-1:0]  step_size;
    logic [DATA_W-1:0] sh_y;
    logic              sh_cout;
    logic              sh_ovf;

    shifter u_shifter (
        .ctrl     (step_ctrl),
        .a        (work_q),
        .y        (sh_y),
        .cout     (sh_cout),
        .overflow (sh_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_LSR;
            cnt_q   <= '0;
            work_q  <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Step decode: LSL takes 16-bit strides while at least 16 remain.
    always_comb begin
        step_ctrl = SH_NOP;
        step_size = '0;
        if (state_q == S_SHIFT) begin
            case (op_q)
                OP_LSL: begin
                    if (cnt_q >= 5'd16) begin
                        step_ctrl = SH_LSL16;
                        step_size = 5'd16;
                    end else begin
                        step_ctrl = SH_LSL1;
                        step_size = 5'd1;
                    end
                end
                OP_LSR: begin
                    step_ctrl = SH_LSR1;
                    step_size = 5'd1;
                end
                OP_ASR: begin
                    step_ctrl = SH_ASR1;
                    step_size = 5'd1;
                end
                default: begin
                    step_ctrl = SH_NOP;
                    step_size = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d = din;
                    cnt_d  = amount;
                    op_d   = op_e'(op);
                    cout_d = 1'b0;
                    ovf_d  = 1'b0;
                    if (amount == '0 || op == OP_RSV) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                work_d = sh_y;
                cnt_d  = cnt_q - step_size;
                cout_d = cout_q | sh_cout;
                ovf_d  = ovf_q | sh_ovf;
                if (cnt_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == S_SHIFT) || (state_q == S_DONE);
        done     = (state_q == S_DONE);
        dout     = work_q;
        cout     = cout_q;
        overflow = ovf_q;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-003 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-004 SHALL have port op  input  2  operation: 00 LSR, 01 LSL, 10 ASR, 11 reserved.
REQ-005 SHALL have port amount  input  5  shift distance 0..31.
REQ-006 SHALL have port din  input  32  operand.
REQ-007 SHALL have port busy  output  1  high in SHIFT and DONE states.
REQ-008 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-009 SHALL have port dout  output  32  shifted result.
REQ-010 SHALL have port cout  output  1  sticky carry flag.
REQ-011 SHALL have port overflow  output  1  sticky overflow flag.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1: SHALL load work register <= din, counter <= amount, latch op, clear cout/overflow; next state SHIFT, or DONE if amount=0 or op=11.
REQ-014 In SHIFT: each cycle SHALL apply exactly one step to the work register through the shifter instance and decrement the counter by the step size.
REQ-015 Step selection: LSL with counter>=16 -> shifter code 011 (16 bits); LSL otherwise -> 010; LSR -> 001; ASR -> 101; each 1-bit step size 1.
REQ-016 SHALL leave SHIFT for DONE in the cycle where the counter reaches 0 after the step.
REQ-017 In DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Latency: done high N+1 cycles after the accept edge, where N = floor(amount/16)+amount%16 for LSL, N = amount for LSR/ASR; amount=0 or op=11 -> done in the cycle after accept.
REQ-019 cout, overflow SHALL be the OR of the shifter cout/overflow outputs over every executed step.
REQ-020 dout, cout, overflow SHALL hold their values from DONE until the next accept.
REQ-021 start while busy=1 (SHIFT or DONE) SHALL be ignored; it is not queued.
REQ-022 op, amount, din changes after accept SHALL NOT affect the operation in progress.
REQ-023 op=11 SHALL produce dout=din, cout=0, overflow=0.

Reset
REQ-024 rst=1 SHALL force IDLE immediately, regardless of clk.
REQ-025 Reset values: busy=0, done=0, dout=0, cout=0, overflow=0, counter=0.
REQ-026 Reset during SHIFT SHALL abandon the operation with no done pulse.

Structure
REQ-027 Op codes (LSR/LSL/ASR/reserved), shifter control codes (000/001/010/011/101), and state encodings SHALL live in a shared defines include file used by shifter users.
REQ-028 SHALL instantiate one existing shifter sub-module (name: shifter) on the work register; no other sub-modules.
REQ-029 Target size 120-400 RTL lines; one always block for state/registers, combinational step decode.

Verification
REQ-030 LSR din=0x80000000, amount=4 -> 4 SHIFT cycles, dout=0x08000000, cout=0, overflow=1.
REQ-031 LSL din=0x00000001, amount=20 -> 5 SHIFT cycles (16+4), dout=0x00100000, cout=0, overflow=0.
REQ-032 ASR din=0x80000000, amount=31 -> 31 SHIFT cycles, dout=0xFFFFFFFF, flags 0; LSL din=0xC0000000, amount=1 -> dout=0x80000000, cout=1, overflow=0.
REQ-033 amount=0, din=0x12345678 -> done in the cycle after accept, dout=0x12345678; op=11 amount=7 -> identical behaviour.
REQ-034 start pulsed during SHIFT with different din -> ignored; original result produced, single done pulse.
REQ-035 rst asserted mid-SHIFT (between clock edges) -> busy=0, dout=0 immediately, no done; next request completes normally.
